// File: rtl/ifm_pkg.sv
// Shared definitions for the instruction fetch memory: fault codes, the NOP
// returned on a faulted fetch, and the fetch classification rule.
package ifm_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_e;

    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    // Misalignment wins over range: a misaligned address is reported as such
    // even when it also lies outside the memory.
    function automatic fault_e classify(input logic [1:0] low_bits, input logic above_range);
        if (low_bits != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if (above_range) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/ifm_rsp_fifo.sv
// Two-entry in-order response buffer. The head sits in its own register so the
// response outputs never see a combinational path from the push side.
module ifm_rsp_fifo #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] tail;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && (count != 2'd2);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (do_push) begin
                        head  <= din;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (do_push && do_pop) begin
                        head <= din;
                    end else if (do_push) begin
                        tail  <= din;
                        count <= 2'd2;
                    end else if (do_pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (do_pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, a program-load port and a
// two-entry response buffer; bad fetches return a NOP with a fault code.
module instr_fetch_mem
    import ifm_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_fault,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int RSP_W = DATA_W + ADDR_W + 2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              above_range;
    fault_e            fault;
    logic [DATA_W-1:0] instr;
    logic              accept;
    logic              pop;
    logic [1:0]        count;
    logic [RSP_W-1:0]  head;

    // NOTE: the memory array has no reset; program contents must survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && !reset) begin
            mem[ld_idx] <= ld_data;
        end
    end

    assign idx         = req_addr[IDX_W+1:2];
    assign above_range = (req_addr >> (IDX_W + 2)) != '0;
    assign fault       = classify(req_addr[1:0], above_range);
    assign instr       = (fault == FAULT_NONE) ? mem[idx] : DATA_W'(NOP_INSTR);

    // Ready looks only at control and occupancy, never at req_valid or rsp_ready.
    assign req_ready = !reset && !flush && !ld_en && (count < 2'd2);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;

    ifm_rsp_fifo #(
        .W(RSP_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (accept),
        .pop   (pop),
        .din   ({instr, req_addr, fault}),
        .count (count),
        .head  (head)
    );

    assign {rsp_instr, rsp_addr, rsp_fault} = head;

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised instruction memory with a valid/ready fetch port, a program-load write port and a 2-entry response buffer, sitting between the fetch stage's PC logic and the decode stage. Fetch addresses are byte addresses, must be word-aligned, and are range-checked. Misaligned or out-of-range fetches return a NOP plus a fault code instead of arbitrary data. A flush input discards buffered responses on a branch redirect.

## Interface
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, fetch byte-address width
- DEPTH, 256, memory depth in words (power of two, ≥4)
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridable)

- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard buffered responses this cycle
- req_valid  in  1  fetch request valid
- req_ready  out  1  request accepted when valid && ready
- req_addr  in  ADDR_W  fetch byte address
- rsp_valid  out  1  response valid (head of buffer)
- rsp_ready  in  1  consumer accepts response
- rsp_instr  out  DATA_W  instruction word, or NOP on fault
- rsp_addr  out  ADDR_W  byte address of this response
- rsp_fault  out  2  0 none, 1 misaligned, 2 out of range
- ld_en  in  1  write ld_data to mem[ld_idx]
- ld_idx  in  IDX_W  word index for load
- ld_data  in  DATA_W  load data

## Operation
- Storage: DEPTH×DATA_W words, contents not cleared by reset.
- Word index = req_addr[IDX_W+1:2].
- Request acceptance: req_ready = !reset && !flush && !ld_en && (count < 2).
- On accept, the block classifies the request and pushes the response into the buffer at the same clock edge:
  - req_addr[1:0] != 0 → fault 1, instr NOP. This class takes priority.
  - req_addr >> 2 ≥ DEPTH, i.e. any bit above IDX_W+1 is set → fault 2, instr NOP.
  - Otherwise fault 0, instr = mem[index].
- NOP = 32'hE1A00000 (MOV r0,r0).
- Response buffer: 2-entry FIFO in order. The head drives rsp_*; pop when rsp_valid && rsp_ready.
- Push and pop in the same cycle: count unchanged. This is legal at count 1.
- At count 2, req_ready stays low even if a pop occurs that cycle. There is no same-cycle bypass.
- Load: ld_en writes the memory at the clock edge. While ld_en is high, the block accepts no fetch. A fetch accepted the cycle after a load to the same index returns the new data.
- Flush: at the edge, the buffer is emptied, count is set to 0, and any pop that cycle is ignored. No request is accepted in a flush cycle.
- Reset: count 0, rsp_valid 0, rsp_instr 0, rsp_addr 0, rsp_fault 0. Pending responses are lost. A load asserted during reset is ignored.
- The buffer may be emptied while a load is in progress, since loads only block requests.

## Timing
- Latency: request accepted at edge N → rsp_valid high from cycle N+1, when the buffer was empty.
- Throughput: 1 fetch per cycle while rsp_ready is held high.
- req_ready is combinational from flush, ld_en, reset and count only. It does not depend on req_valid or rsp_ready.
- rsp_* are driven from buffer registers only: no combinational path from req_* to rsp_*.
- rsp_* remain stable while rsp_valid && !rsp_ready.
- Memory write and read-for-push happen on the same edge. They never conflict, because ld_en blocks requests.

## Structure
- Shared package ifm_pkg holds:
  - fault codes FAULT_NONE=0, FAULT_MISALIGN=1, FAULT_RANGE=2
  - NOP_INSTR=32'hE1A00000
- Sub-module ifm_rsp_fifo: 2-entry FIFO, width DATA_W+ADDR_W+2, with push, pop, flush, count, head outputs, and synchronous reset.
- The top level holds the memory array, classification logic, load port and the ready equation.

## Test plan
- Load mem[0..2] = 32'hE5312004, 32'hE2811001, 32'hEAFFFFFE, then fetch 0, 4, 8 back-to-back with rsp_ready=1 → three responses on consecutive cycles, in order, fault 0, correct words and addresses.
- Fetch addr 32'h6 → rsp_instr 32'hE1A00000, fault 1. Fetch 32'h400 with DEPTH=256 → NOP, fault 2. Fetch 32'h402 → fault 1, showing misalignment has priority.
- Hold rsp_ready=0 and issue 3 requests → the first 2 are accepted and req_ready drops. Release rsp_ready → the third is accepted one cycle after the first pop, and order is preserved.
- Two responses buffered, then assert flush together with req_valid → the next cycle rsp_valid=0, count 0, and the request was not accepted.
- Assert ld_en on idx 1 with data 32'hDEADBEEF while req_valid is high → req_ready=0. The next cycle, fetch 4 → 32'hDEADBEEF.
- Reset with 2 responses buffered → all outputs are 0 the cycle after reset. Memory contents survive: a refetch of 0 returns 32'hE5312004.
